// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point output scaler.
// Holds the error codes, the framing FSM state type and the helper that
// gives the signed saturation limits of an output width.
package bfp_pkg;

    localparam int unsigned ERR_W = 2;

    localparam logic [ERR_W-1:0] ERR_NONE        = 2'b00;
    localparam logic [ERR_W-1:0] ERR_MISSING_SOP = 2'b01;
    localparam logic [ERR_W-1:0] ERR_MISSING_EOP = 2'b10;
    localparam logic [ERR_W-1:0] ERR_BAD_EXP     = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } frame_state_e;

    // Largest (want_min=0) or smallest (want_min=1) two's complement value of 'width' bits.
    function automatic longint sat_limit(input int unsigned width, input logic want_min);
        if (want_min) begin
            return -(64'sd1 <<< (width - 1));
        end
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/bfp_shift_sat.sv
// Combinational shift/saturate for one sample component: out = din * 2^(-exp_val).
// Negative exponents shift left (saturating to the OUT_W range), positive ones
// shift right (floor, or round half away from zero when BFP_SCALER_ROUND_EN
// is defined).
// Ports: din (DIN_W, two's complement), exp_val (EXP_W, signed),
//        dout_c (OUT_W result), sat_c (result was clamped).
module bfp_shift_sat
    import bfp_pkg::*;
#(
    parameter int unsigned DIN_W   = 17,
    parameter int unsigned OUT_W   = 17,
    parameter int unsigned EXP_W   = 6,
    parameter int unsigned LSH_MAX = 14
) (
    input  logic [DIN_W-1:0] din,
    input  logic [EXP_W-1:0] exp_val,
    output logic [OUT_W-1:0] dout_c,
    output logic             sat_c
);

    // Wide enough that the largest legal left shift cannot overflow.
    localparam int unsigned WIDE_W = DIN_W + LSH_MAX + 2;
    localparam logic signed [WIDE_W-1:0] HI = WIDE_W'(sat_limit(OUT_W, 1'b0));
    localparam logic signed [WIDE_W-1:0] LO = WIDE_W'(sat_limit(OUT_W, 1'b1));

    logic signed [WIDE_W-1:0] x;
    logic signed [WIDE_W-1:0] shifted;
    logic                     neg_exp;
    logic [EXP_W-1:0]         mag;

    assign neg_exp = exp_val[EXP_W-1];
    assign mag     = neg_exp ? (~exp_val + EXP_W'(1)) : exp_val;
    assign x       = WIDE_W'($signed(din));

`ifdef BFP_SCALER_ROUND_EN
    logic [WIDE_W-1:0] frac;
    logic [WIDE_W-1:0] half;
    logic              rnd;

    // Increment the floored result when the dropped fraction is above one half,
    // or exactly one half on a non-negative value (ties move away from zero).
    always_comb begin
        frac = x & ((WIDE_W'(1) << mag) - WIDE_W'(1));
        half = (WIDE_W'(1) << mag) >> 1;
        rnd  = (mag != '0) && ((frac > half) || ((frac == half) && !x[WIDE_W-1]));
    end
`endif

    // Shift, then clamp to the output range.
    always_comb begin
        if (neg_exp) begin
            shifted = x <<< mag;
        end else begin
            shifted = x >>> mag;
`ifdef BFP_SCALER_ROUND_EN
            if (rnd) begin
                shifted = shifted + WIDE_W'(1);
            end
`endif
        end
        sat_c  = 1'b0;
        dout_c = OUT_W'(shifted);
        if (shifted > HI) begin
            sat_c  = 1'b1;
            dout_c = OUT_W'(HI);
        end else if (shifted < LO) begin
            sat_c  = 1'b1;
            dout_c = OUT_W'(LO);
        end
    end

endmodule

// File: rtl/bfp_scaler_pipe.sv
// Block-floating-point output scaler: source = sink * 2^(-exp) on complex
// samples, two-stage Avalon-ST pipeline (ready latency 0) with SOP/EOP checks.
// Optional build macro: BFP_SCALER_ROUND_EN (round half away from zero on
// right shifts instead of truncating toward -inf).
// Ports:
//   clk, reset_n                        clock, synchronous active-low reset
//   sink_valid/ready/sop/eop            input handshake and framing
//   sink_real/imag [IN_W], sink_exp [EXP_W], sink_error [2]
//   source_valid/ready/sop/eop          output handshake and framing
//   source_real/imag [OUT_W], source_error [2]
//   sat_flag                            sticky saturation of current/last frame
module bfp_scaler_pipe
    import bfp_pkg::*;
#(
    parameter int unsigned IN_W          = 16,
    parameter int unsigned OUT_W         = 17,
    parameter int unsigned EXP_W         = 6,
    parameter int          MIN_EXP       = -14,
    parameter int          MAX_EXP       = 2,
    parameter int unsigned EXP_PER_FRAME = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sink_valid,
    output logic                 sink_ready,
    input  logic                 sink_sop,
    input  logic                 sink_eop,
    input  logic [IN_W-1:0]      sink_real,
    input  logic [IN_W-1:0]      sink_imag,
    input  logic [EXP_W-1:0]     sink_exp,
    input  logic [ERR_W-1:0]     sink_error,
    output logic                 source_valid,
    input  logic                 source_ready,
    output logic                 source_sop,
    output logic                 source_eop,
    output logic [OUT_W-1:0]     source_real,
    output logic [OUT_W-1:0]     source_imag,
    output logic [ERR_W-1:0]     source_error,
    output logic                 sat_flag
);

    localparam int unsigned LSH_MAX = (MIN_EXP < 0) ? 32'(-MIN_EXP) : 32'd0;

    // Stage 1 registers
    logic               s1_valid;
    logic               s1_sop;
    logic               s1_eop;
    logic               s1_bad_exp;
    logic [OUT_W-1:0]   s1_real;
    logic [OUT_W-1:0]   s1_imag;
    logic [EXP_W-1:0]   s1_exp;
    logic [ERR_W-1:0]   s1_err;
    logic [EXP_W-1:0]   held_exp;
    frame_state_e       state;

    // Saturation of the beat currently held in stage 2
    logic               s2_sat;

    logic               accept_c;
    logic               s2_load_c;
    logic               s2_pop_c;
    logic [EXP_W-1:0]   eff_exp_c;
    logic               bad_exp_c;
    logic [ERR_W-1:0]   frame_err_c;
    logic [ERR_W-1:0]   beat_err_c;
    logic [OUT_W-1:0]   re_scaled_c;
    logic [OUT_W-1:0]   im_scaled_c;
    logic               re_sat_c;
    logic               im_sat_c;
    logic               beat_sat_c;
    logic               sat_next_c;

    // Stage 1 can take a beat whenever it is empty or will move on this edge.
    assign sink_ready = !s1_valid || !source_valid || source_ready;
    assign accept_c   = sink_valid && sink_ready;
    assign s2_load_c  = s1_valid && (!source_valid || source_ready);
    assign s2_pop_c   = source_valid && source_ready;

    assign eff_exp_c = ((EXP_PER_FRAME != 0) && !sink_sop) ? held_exp : sink_exp;
    assign bad_exp_c = (int'($signed(eff_exp_c)) < MIN_EXP) ||
                       (int'($signed(eff_exp_c)) > MAX_EXP);

    // Framing check of the incoming beat and final error code selection.
    always_comb begin
        frame_err_c = ERR_NONE;
        if ((state == IDLE) && !sink_sop) begin
            frame_err_c = ERR_MISSING_SOP;
        end
        if ((state == INFRAME) && sink_sop) begin
            frame_err_c = ERR_MISSING_EOP;
        end
        if (sink_error != ERR_NONE) begin
            beat_err_c = sink_error;
        end else if (bad_exp_c) begin
            beat_err_c = ERR_BAD_EXP;
        end else begin
            beat_err_c = frame_err_c;
        end
    end

    // Stage 1: capture the beat, latch the frame exponent, advance framing FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_sop     <= 1'b0;
            s1_eop     <= 1'b0;
            s1_bad_exp <= 1'b0;
            s1_real    <= '0;
            s1_imag    <= '0;
            s1_exp     <= '0;
            s1_err     <= ERR_NONE;
            held_exp   <= '0;
            state      <= IDLE;
        end else if (accept_c) begin
            s1_valid   <= 1'b1;
            s1_sop     <= sink_sop;
            s1_eop     <= sink_eop;
            s1_bad_exp <= bad_exp_c;
            s1_real    <= OUT_W'($signed(sink_real));
            s1_imag    <= OUT_W'($signed(sink_imag));
            s1_exp     <= eff_exp_c;
            s1_err     <= beat_err_c;
            if (sink_sop) begin
                held_exp <= sink_exp;
            end
            case (state)
                IDLE:    if (sink_sop && !sink_eop) state <= INFRAME;
                INFRAME: if (sink_eop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    bfp_shift_sat #(
        .DIN_W   (OUT_W),
        .OUT_W   (OUT_W),
        .EXP_W   (EXP_W),
        .LSH_MAX (LSH_MAX)
    ) u_shift_re (
        .din     (s1_real),
        .exp_val (s1_exp),
        .dout_c  (re_scaled_c),
        .sat_c   (re_sat_c)
    );

    bfp_shift_sat #(
        .DIN_W   (OUT_W),
        .OUT_W   (OUT_W),
        .EXP_W   (EXP_W),
        .LSH_MAX (LSH_MAX)
    ) u_shift_im (
        .din     (s1_imag),
        .exp_val (s1_exp),
        .dout_c  (im_scaled_c),
        .sat_c   (im_sat_c)
    );

    assign beat_sat_c = !s1_bad_exp && (re_sat_c || im_sat_c);

    // Sticky flag: an SOP beat leaving restarts it from its own saturation,
    // any saturating beat entering stage 2 sets it.
    always_comb begin
        sat_next_c = sat_flag;
        if (s2_pop_c && source_sop) begin
            sat_next_c = s2_sat;
        end
        if (s2_load_c && beat_sat_c) begin
            sat_next_c = 1'b1;
        end
    end

    // Stage 2: scaled result, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            source_error <= ERR_NONE;
            s2_sat       <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            sat_flag <= sat_next_c;
            if (s2_load_c) begin
                source_valid <= 1'b1;
                source_sop   <= s1_sop;
                source_eop   <= s1_eop;
                source_real  <= s1_bad_exp ? '0 : re_scaled_c;
                source_imag  <= s1_bad_exp ? '0 : im_scaled_c;
                source_error <= s1_err;
                s2_sat       <= beat_sat_c;
            end else if (s2_pop_c) begin
                source_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bfp_scaler_pipe.md
Name: bfp_scaler_pipe

Overview:
- Parametrised block-floating-point output scaler for the FFT/IFFT datapath; sits between the BFP FFT core source port and downstream magnitude/accumulation logic.
- Applies out = in × 2^(−exp) to complex samples, with saturation, optional rounding and a frame-consistent exponent.
- Full Avalon-ST backpressure (ready latency 0) through a 2-stage pipeline, plus SOP/EOP framing checks.

Parameters:
- IN_W, 16: input real/imag width, two's complement.
- OUT_W, 17: output real/imag width; must be ≥ IN_W.
- EXP_W, 6: exponent width, signed.
- MIN_EXP, −14: most negative legal exponent (largest left shift).
- MAX_EXP, 2: most positive legal exponent (largest right shift).
- EXP_PER_FRAME, 1: 1 = exponent sampled on the SOP beat and held for the frame; 0 = sink_exp used on every beat.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- sink_valid  in  1  input beat valid
- sink_ready  out  1  input accept
- sink_sop  in  1  start of frame
- sink_eop  in  1  end of frame
- sink_real  in  IN_W  real sample
- sink_imag  in  IN_W  imaginary sample
- sink_exp  in  EXP_W  signed BFP exponent
- sink_error  in  2  upstream error code
- source_valid  out  1  output beat valid
- source_ready  in  1  downstream accept
- source_sop  out  1  start of frame
- source_eop  out  1  end of frame
- source_real  out  OUT_W  scaled real
- source_imag  out  OUT_W  scaled imaginary
- source_error  out  2  error code
- sat_flag  out  1  sticky: a saturation occurred in the current or last frame

Behaviour:
- Reset (clk edge with reset_n=0): all outputs 0, both pipeline stages empty, framing FSM in IDLE, held exponent 0.
- Reset mid-frame: partial frame discarded; no output beats emitted for it.
- Accept and pipeline:
  - A beat is accepted when sink_valid & sink_ready.
  - sink_ready = !s1_valid | !s2_valid | source_ready.
  - Stage 1 registers the sign-extended sample, effective exponent and error code. Stage 2 registers the scaled result.
  - Latency is 2 cycles when unstalled; throughput is 1 beat/clk.
  - A stage holds its contents while the stage after it is full and not draining. No beat is dropped or duplicated.
  - Output fields are held stable while source_valid & !source_ready.
- Effective exponent:
  - EXP_PER_FRAME=1: on an SOP beat it is sink_exp, which is also latched. On later beats it is the latched value.
  - EXP_PER_FRAME=0: sink_exp on every beat.
- Scaling, with e = effective exponent:
  - e<0: arithmetic left shift by −e. If the true result exceeds the OUT_W range, saturate to +2^(OUT_W−1)−1 or −2^(OUT_W−1) and set sat_flag.
  - e=0: sign-extend only.
  - e>0: arithmetic right shift by e, truncating toward −∞.
  - e outside [MIN_EXP, MAX_EXP]: data forced to 0, local error 11.
- Framing FSM (advances on accepted beats only):
  - IDLE: SOP goes to INFRAME. SOP with EOP stays IDLE (single-beat frame). A beat without SOP gives local error 01 and stays IDLE.
  - INFRAME: EOP goes to IDLE. SOP gives local error 10, restarts the frame and relatches the exponent.
  - SOP/EOP are passed through unchanged.
- source_error: sink_error if nonzero, otherwise the local code, otherwise 00. Priority among local codes: 11 > 10 > 01.
- sat_flag: cleared when an SOP beat leaves stage 2; set by any saturating beat, including that same beat.

Optional Feature:
- Macro BFP_SCALER_ROUND_EN.
- Defined: right shifts round half away from zero. Adding the rounding bit may overflow the positive limit; that case saturates and sets sat_flag.
- Undefined: truncation as above. Left shifts are identical in both builds.

Decomposition:
- Package bfp_pkg holds:
  - error code constants ERR_NONE=00, ERR_MISSING_SOP=01, ERR_MISSING_EOP=10, ERR_BAD_EXP=11;
  - FSM state enum {IDLE, INFRAME};
  - a function giving the OUT_W saturation limits.
- One sub-module, bfp_shift_sat: combinational shift/saturate/round for a single component, instantiated for real and for imag.

Test Plan:
- Frame of 4 beats, exp=−3, real=0x0005, imag=0xFFFB, source_ready=1 → outputs appear 2 cycles after input, real=40, imag=−40, error 00, sat_flag=0.
- exp=−14, real=0x7FFF → real=0x0FFFF (17-bit max), sat_flag=1. The next SOP beat with exp=0 clears sat_flag when it exits.
- exp=+2, real=−5 → −2 when BFP_SCALER_ROUND_EN is undefined, −1 when defined. exp=+3 on SOP → data 0, error 11.
- Random source_ready at 50% over a 64-beat frame, EXP_PER_FRAME=1, sink_exp changing mid-frame → all beats use the SOP exponent; output order and count match input; fields stable during stalls.
- Beat without SOP in IDLE → error 01. SOP inside a frame → error 10. sink_error=01 on a beat with a bad exponent → error 01.
- reset_n low for 1 cycle mid-frame → next cycle source_valid=0 and FSM in IDLE; a new frame processes normally.
